// File: rtl/sync_debounce.sv
// sync_debounce: consecutive-sample stability filter for a synchronized 1-bit level,
// with registered rise/fall pulses. Define SYNC_DEBOUNCE_EVT_CNT_EN for the event counter.
`timescale 1ns/1ps
module sync_debounce #(
  parameter int   STABLE_CNT  = 16,
  parameter logic INITIAL_VAL = 1'b0
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  ,
  parameter int   EVT_W       = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_sync,
  input  logic             sample_en,
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  input  logic             evt_clr,
  output logic [EVT_W-1:0] evt_cnt,
`endif
  output logic             level,
  output logic             rise,
  output logic             fall
);

  localparam int            CW       = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  if (STABLE_CNT < 1 || STABLE_CNT > 65535) begin : g_param_check
    $error("sync_debounce: STABLE_CNT must be in 1..65535");
  end

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_level;
  logic          w_level_nxt;
  logic          r_rise;
  logic          w_rise_nxt;
  logic          r_fall;
  logic          w_fall_nxt;
  logic          w_differ;

  assign w_differ = d_sync ^ r_level;

  // Next-state logic; the count is always zero in STABLE, so a single sample
  // can only be accepted there when STABLE_CNT is 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (sample_en) begin
      case (r_state)
        ST_STABLE: begin
          if (!w_differ) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STABLE;
          end else if (STABLE_CNT == 1) begin
            w_level_nxt = ~r_level;
            w_rise_nxt  = ~r_level;
            w_fall_nxt  = r_level;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STABLE;
          end else begin
            w_cnt_nxt   = CW'(1);
            w_state_nxt = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (!w_differ) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STABLE;
          end else if (r_cnt == CNT_LAST) begin
            w_level_nxt = ~r_level;
            w_rise_nxt  = ~r_level;
            w_fall_nxt  = r_level;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STABLE;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
            w_state_nxt = ST_PENDING;
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STABLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, counter, level and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_level <= INITIAL_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  logic [EVT_W-1:0] r_evt_cnt;

  // Saturating count of emitted pulses; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_evt_cnt <= '0;
    end else if (evt_clr) begin
      r_evt_cnt <= '0;
    end else if ((r_rise || r_fall) && (r_evt_cnt != EVT_MAX)) begin
      r_evt_cnt <= r_evt_cnt + EVT_W'(1);
    end else begin
      r_evt_cnt <= r_evt_cnt;
    end
  end

  assign evt_cnt = r_evt_cnt;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench for sync_debounce: vector table through a scoreboard queue
// for STABLE_CNT=4, plus a hand-written sequence on a STABLE_CNT=1 instance.
`timescale 1ns/1ps
module tb_sync_debounce;

  typedef struct {
    logic rst;
    logic d;
    logic s;
    logic clr;
    logic lvl;
    logic ri;
    logic fa;
  } vec_t;

  logic clk = 1'b0;
  logic reset, d_sync, sample_en, evt_clr;
  logic level, rise, fall;
  logic reset1, d1, s1, clr1;
  logic level1, rise1, fall1;
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  logic [1:0] evt_cnt;
  logic [7:0] evt_cnt1;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];
  vec_t sb[$];
  vec_t sb1[$];
  int   exp_evt = 0;
  logic prev_pulse = 1'b0;

  always #5 clk = ~clk;

  sync_debounce #(
    .STABLE_CNT (4),
    .INITIAL_VAL(1'b0)
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    , .EVT_W    (2)
`endif
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .d_sync   (d_sync),
    .sample_en(sample_en),
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    .evt_clr  (evt_clr),
    .evt_cnt  (evt_cnt),
`endif
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  sync_debounce #(
    .STABLE_CNT (1),
    .INITIAL_VAL(1'b1)
  ) u_dut1 (
    .clk      (clk),
    .reset    (reset1),
    .d_sync   (d1),
    .sample_en(s1),
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    .evt_clr  (clr1),
    .evt_cnt  (evt_cnt1),
`endif
    .level    (level1),
    .rise     (rise1),
    .fall     (fall1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic d, input logic s, input logic c,
                     input logic l, input logic ri, input logic fa);
    vec_t v;
    v.rst = r; v.d = d; v.s = s; v.clr = c; v.lvl = l; v.ri = ri; v.fa = fa;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    reset = v.rst; d_sync = v.d; sample_en = v.s; evt_clr = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d level", idx), {31'd0, level}, {31'd0, e.lvl});
    chk($sformatf("v%0d rise", idx), {31'd0, rise}, {31'd0, e.ri});
    chk($sformatf("v%0d fall", idx), {31'd0, fall}, {31'd0, e.fa});
    chk($sformatf("v%0d excl", idx), {31'd0, rise & fall}, 32'd0);
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    if (e.rst || e.clr) exp_evt = 0;
    else if (prev_pulse && exp_evt < 3) exp_evt++;
    prev_pulse = e.ri | e.fa;
    chk($sformatf("v%0d evt_cnt", idx), {30'd0, evt_cnt}, exp_evt);
`endif
  endtask

  task automatic apply1(input logic r, input logic d, input logic s,
                        input logic l, input logic ri, input logic fa, input string name);
    vec_t v;
    vec_t e;
    v.rst = r; v.d = d; v.s = s; v.clr = 1'b0; v.lvl = l; v.ri = ri; v.fa = fa;
    @(negedge clk);
    reset1 = r; d1 = d; s1 = s;
    sb1.push_back(v);
    @(posedge clk);
    #1;
    e = sb1.pop_front();
    chk({name, " level"}, {31'd0, level1}, {31'd0, e.lvl});
    chk({name, " rise"}, {31'd0, rise1}, {31'd0, e.ri});
    chk({name, " fall"}, {31'd0, fall1}, {31'd0, e.fa});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; d_sync = 1'b1; sample_en = 1'b1; evt_clr = 1'b0;
    reset1 = 1'b1; d1 = 1'b0; s1 = 1'b1; clr1 = 1'b0;

    // Reset release with d_sync already high: rise 4 clocks after reset drops
    repeat (2) add(1, 1, 1, 0, 0, 0, 0);
    repeat (3) add(0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0);
    add(0, 1, 1, 1, 1, 0, 0);
    // Clean fall, clean rise, clean fall
    repeat (3) add(0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    repeat (3) add(0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    repeat (3) add(0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    // Glitch reject on the low side, then an accepted run
    repeat (3) add(0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    repeat (3) add(0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    // Glitch reject on the high side, then fall
    repeat (2) add(0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    repeat (3) add(0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    // Sample qualifier every 3rd clock: rise on the 10th clock
    for (int k = 1; k <= 11; k++)
      add(0, 1, logic'(k % 3 == 1), logic'(k == 11), logic'(k >= 10), logic'(k == 10), 0);
    // Back to 0, then reset mid-pending discards the partial count
    repeat (3) add(0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    repeat (2) add(0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    repeat (3) add(0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    // Reset with level high returns to INITIAL_VAL without a fall pulse
    add(1, 1, 1, 0, 0, 0, 0);
    repeat (3) add(0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0);
    // sample_en low on what would be the accepting edge holds everything
    repeat (3) add(0, 0, 1, 0, 1, 0, 0);
    repeat (2) add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // STABLE_CNT=1, INITIAL_VAL=1: registered passthrough with pulses
    apply1(1, 0, 1, 1, 0, 0, "p1 reset");
    apply1(0, 0, 1, 0, 0, 1, "p1 fall");
    apply1(0, 0, 1, 0, 0, 0, "p1 hold0");
    apply1(0, 1, 1, 1, 1, 0, "p1 rise");
    apply1(0, 0, 1, 0, 0, 1, "p1 fall2");
    apply1(0, 1, 0, 0, 0, 0, "p1 gated");
    apply1(0, 1, 1, 1, 1, 0, "p1 rise2");
    apply1(0, 1, 1, 1, 0, 0, "p1 idle");
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    chk("p1 evt_cnt", {24'd0, evt_cnt1}, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Downstream consumer of the 1-bit CDC synchronizer output, in the destination clock domain.
- Filters the synchronized level with a consecutive-sample stability counter.
- Produces a debounced level plus single-cycle rise and fall event pulses.
- Used for buttons, external strobes and slow status lines after synchronization.

Parameters:
- STABLE_CNT, 16: consecutive qualifying samples of the new value needed to accept a transition; legal range 1 to 65535.
- INITIAL_VAL, 1'b0: reset value of the debounced level.
- EVT_W, 8: width of the event counter (optional feature only).

Ports:
- clk  input  1: destination clock, same domain as the synchronizer output.
- reset  input  1: synchronous reset, active-high.
- d_sync  input  1: synchronized input level; must already be in the clk domain.
- sample_en  input  1: sample qualifier (prescaler tick); tie to 1 to sample every cycle.
- level  output  1: debounced level.
- rise  output  1: one-cycle pulse when level goes 0->1.
- fall  output  1: one-cycle pulse when level goes 1->0.
- evt_clr  input  1: event counter clear (optional feature only).
- evt_cnt  output  EVT_W: accepted-transition count (optional feature only).

Behaviour:
- Reset: one clock with reset=1.
  - level=INITIAL_VAL; rise=0; fall=0; counter=0; state=STABLE.
  - Reset overrides everything else on that edge.
  - Reset mid-pending discards the partial count. No pulse is produced, even if d_sync differs from INITIAL_VAL after reset.
- Internal counter width is $clog2(STABLE_CNT+1). Instantiation with STABLE_CNT<1 fails at elaboration.
- FSM has two states:
  - STABLE: d_sync == level at the last qualified sample; counter=0.
  - PENDING: d_sync != level; counter holds the number of consecutive differing qualified samples.
- Each rising clk edge with sample_en=1 and reset=0:
  - d_sync == level: counter<=0; state<=STABLE. This is a glitch abort; no pulse.
  - d_sync != level and counter == STABLE_CNT-1: level<=~level; counter<=0; state<=STABLE. Assert rise if the new level is 1, fall if it is 0.
  - d_sync != level otherwise: counter<=counter+1; state<=PENDING.
- Edge with sample_en=0: state, counter and level hold; rise=fall=0.
- Latency: level changes on the edge of the STABLE_CNT-th consecutive differing qualified sample.
  - With sample_en=1: STABLE_CNT clocks after d_sync changes.
  - STABLE_CNT=1 gives a registered passthrough with 1-cycle latency.
- Pulses:
  - rise/fall are registered and high for exactly the one cycle following the edge on which level updated.
  - rise and fall are never both high.
  - rise, fall and level change together: the updated level and its pulse are visible in the same cycle.
- A toggle of d_sync during PENDING resets the count; only uninterrupted runs are accepted.
- The counter never exceeds STABLE_CNT-1; no wrap is possible.

Optional Feature:
- Macro SYNC_DEBOUNCE_EVT_CNT_EN.
- Defined:
  - Ports evt_clr and evt_cnt exist.
  - evt_cnt resets to 0 and increments by 1 on each cycle where rise or fall is asserted.
  - evt_cnt saturates at 2^EVT_W-1.
  - evt_clr=1 forces evt_cnt to 0 on the next edge. Clear wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is generated. Core behaviour is identical.

Test Plan:
- Reset release: STABLE_CNT=4, INITIAL_VAL=0, d_sync=1 during reset -> after reset level=0, rise=0; level=1 and rise=1 for one cycle, 4 clocks after reset deasserts.
- Clean step: d_sync 0->1, held, sample_en=1 -> level=1 and rise=1 exactly 4 clocks later. Then d_sync 1->0 -> fall=1 and level=0, 4 clocks later.
- Glitch reject: d_sync high for 3 clocks then low -> level stays 0, no rise. A following 4-clock high run -> rise.
- Sample qualifier: sample_en high every 3rd clock, d_sync held high -> rise on the 4th qualified edge, 10 clocks after the first qualified sample. Counter holds between ticks.
- Reset mid-pending: d_sync high, reset pulsed after 2 counts -> no rise. Count restarts; rise 4 clocks after reset deasserts.
- SYNC_DEBOUNCE_EVT_CNT_EN, EVT_W=2: 5 accepted transitions -> evt_cnt saturates at 3. Assert evt_clr together with a rise -> evt_cnt=0.
